bias_relu_sequencer: RTL
========================

BIAS_RELU_SEQUENCER -- requirements
Module: bias_relu_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 16: output channels per pixel, equal to the bias table depth.
REQ-002 SHALL have parameter NUM_PIX, default 3025: pixels per layer pass.
REQ-003 SHALL have parameter ACC_W, default 32: accumulator width, two's complement, Q16.16.
REQ-004 SHALL have parameter FRAC, default 8: bias alignment shift and output rescale shift.
REQ-005 SHALL use one clock and a synchronous active-high reset; ports are named clk and rst.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 start  input  1  one-cycle pulse that begins a layer pass.
REQ-009 bias_mem  input  16 x NUM_CH  bias table in sign-magnitude format (bit15 = sign), Q8.8.
REQ-010 acc_data  input  ACC_W  accumulator result for the current channel.
REQ-011 acc_valid  input  1  acc_data is valid.
REQ-012 acc_ready  output  1  the block accepts acc_data this cycle.
REQ-013 out_data  output  16  biased, ReLU'd, saturated result, two's complement Q8.8.
REQ-014 out_ch  output  clog2(NUM_CH)  channel index of out_data.
REQ-015 out_last  output  1  out_data is the last channel of the last pixel.
REQ-016 out_valid / out_ready  output / input  1 / 1  output handshake.
REQ-017 busy  output  1  high from the cycle after start is accepted until done is asserted.
REQ-018 done  output  1  one-cycle pulse when the pass completes.

Function
REQ-019 SHALL implement the FSM states IDLE, RUN, DRAIN and DONE.
- IDLE->RUN on start.
- RUN->DRAIN when the final element (pixel NUM_PIX-1, channel NUM_CH-1) is accepted.
- DRAIN->DONE when the pipeline is empty and that final output has been accepted.
- DONE->IDLE unconditionally after 1 cycle.
REQ-020 SHALL ignore start in every state except IDLE.
REQ-021 SHALL drive acc_ready = (state==RUN) && pipeline able to advance.
- A transfer occurs when acc_valid && acc_ready.
REQ-022 SHALL manage the channel counter ch_cnt as follows.
- Reset to 0 on start.
- Increment on each transfer.
- Wrap NUM_CH-1->0 and increment the pixel counter pix_cnt on each wrap.
REQ-023 SHALL form the bias operand for transfer channel c from bias_mem[c].
- magnitude = bits[14:0], negated when bit15 = 1.
- Sign-extend to ACC_W+1 bits, then shift left by FRAC.
- 16'h8000 (negative zero) SHALL yield 0.
REQ-024 SHALL form sum = acc_data (sign-extended to ACC_W+1 bits) + aligned bias, with no wrap.
REQ-025 SHALL compute result = sum arithmetically shifted right by FRAC.
- ReLU: negative results SHALL become 0.
- Saturation: results above 32767 SHALL become 16'h7FFF.
REQ-026 SHALL use a two-stage pipeline.
- Stage 1 registers the sum plus tags (channel, last).
- Stage 2 registers out_data.
- Latency from transfer to out_valid is 2 cycles when unstalled.
REQ-027 SHALL stall the whole pipeline while out_valid && !out_ready.
- out_data, out_ch and out_last SHALL stay stable during a stall.
- No data SHALL be lost or duplicated.
- Full throughput is 1 element per cycle.
REQ-028 SHALL assert out_last only with the element tagged (NUM_PIX-1, NUM_CH-1).
REQ-029 SHALL keep acc_ready low in DRAIN, DONE and IDLE.
- acc_valid in those states SHALL have no effect.

Reset
REQ-030 On rst, SHALL force the state to IDLE.
- Clear ch_cnt, pix_cnt and both pipeline valid bits.
- Drive out_valid, out_last, acc_ready, busy and done to 0.
- Drive out_data and out_ch to 0.
REQ-031 rst asserted mid-pass SHALL abort the pass.
- No done pulse is produced.
- The next start begins at pixel 0, channel 0.

Verification
REQ-032 Basic arithmetic, NUM_PIX=1, bias_mem[0]=16'h021B, acc_data=32'h0001_0000 (1.0).
- Expected out_data=16'h031B, out_ch=0, valid 2 cycles after transfer.
REQ-033 Negative bias with ReLU, bias_mem[1]=16'h8021, acc_data=32'h0000_1000.
- Expected out_data=0.
- acc_data=32'h0000_3000 -> out_data=16'h000F.
REQ-034 Saturation and negative zero.
- acc_data=32'h7FFF_0000, bias 16'h0100 -> out_data=16'h7FFF.
- bias 16'h8000 with acc_data=32'h0000_0500 -> out_data=16'h0005.
REQ-035 Backpressure, random out_ready at 50% over a full pass with NUM_PIX=4.
- Exactly 64 outputs, in channel order 0..15 repeating.
- out_last only on the 64th; done pulses once, after the final handshake.
REQ-036 Control corner cases.
- start pulsed during RUN -> ignored, counters unchanged.
- rst asserted at pixel 2, channel 7 -> all outputs 0 next cycle, no done.
- A subsequent full pass completes correctly.

Source files
------------

// File: rtl/bias_relu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bias_relu_sequencer
//  Description : Adds a per-channel sign-magnitude Q8.8 bias to Q16.16
//                accumulator results, rescales by FRAC, applies ReLU and
//                saturates to a 16-bit Q8.8 output. It walks NUM_PIX pixels
//                of NUM_CH channels per layer pass and uses a two-stage
//                pipeline with full backpressure.
//  Ports       : clk, rst         - clock, synchronous active-high reset
//                start            - one-cycle pulse, begins a pass (IDLE only)
//                bias_mem         - NUM_CH x 16-bit bias table
//                acc_data/valid   - accumulator input, acc_ready handshake
//                out_data/ch/last - result, channel tag, end-of-pass tag
//                out_valid/ready  - output handshake
//                busy, done       - pass in progress / completion pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module bias_relu_sequencer #(
    parameter int NUM_CH  = 16,
    parameter int NUM_PIX = 3025,
    parameter int ACC_W   = 32,
    parameter int FRAC    = 8,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [NUM_CH-1:0][15:0]     bias_mem,
    input  logic [ACC_W-1:0]            acc_data,
    input  logic                        acc_valid,
    output logic                        acc_ready,
    output logic [15:0]                 out_data,
    output logic [CH_W-1:0]             out_ch,
    output logic                        out_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        busy,
    output logic                        done
);

    localparam int PIX_W = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
    // Two guard bits: one for the sign extension, one so the sum never wraps.
    localparam int SUM_W = ACC_W + 2;

    localparam logic [CH_W-1:0]  C_CH_MAX  = CH_W'(NUM_CH - 1);
    localparam logic [PIX_W-1:0] C_PIX_MAX = PIX_W'(NUM_PIX - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [CH_W-1:0]         r_ch_cnt;
    logic [PIX_W-1:0]        r_pix_cnt;
    logic                    r_busy;
    logic                    r_done;

    logic                    r_s1_valid;
    logic signed [SUM_W-1:0] r_s1_sum;
    logic [CH_W-1:0]         r_s1_ch;
    logic                    r_s1_last;

    logic                    r_s2_valid;
    logic [15:0]             r_out_data;
    logic [CH_W-1:0]         r_out_ch;
    logic                    r_out_last;

    logic                    w_advance;
    logic                    w_acc_ready;
    logic                    w_xfer;
    logic                    w_last_elem;
    logic                    w_final_hs;
    logic [15:0]             w_bias_word;
    logic signed [SUM_W-1:0] w_bias_mag;
    logic signed [SUM_W-1:0] w_bias_sgn;
    logic signed [SUM_W-1:0] w_bias_al;
    logic signed [SUM_W-1:0] w_acc_ext;
    logic signed [SUM_W-1:0] w_sum;
    logic signed [SUM_W-1:0] w_shift;
    logic [15:0]             w_result;

    // The whole pipeline moves together; it only holds while the output
    // register carries data that the consumer is refusing.
    assign w_advance   = !(r_s2_valid && !out_ready);
    assign w_acc_ready = (r_state == S_RUN) && w_advance;
    assign w_xfer      = acc_valid && w_acc_ready;
    assign w_last_elem = (r_pix_cnt == C_PIX_MAX) && (r_ch_cnt == C_CH_MAX);
    // Only the final element ever carries the last tag.
    assign w_final_hs  = r_s2_valid && out_ready && r_out_last;

    // Bias alignment: sign-magnitude Q8.8 -> two's complement Q16.16.
    // Negating a zero magnitude gives zero, so 16'h8000 needs no special case.
    assign w_bias_word = bias_mem[r_ch_cnt];
    assign w_bias_mag  = {{(SUM_W-15){1'b0}}, w_bias_word[14:0]};
    assign w_bias_sgn  = w_bias_word[15] ? -w_bias_mag : w_bias_mag;
    assign w_bias_al   = w_bias_sgn <<< FRAC;
    assign w_acc_ext   = {{2{acc_data[ACC_W-1]}}, acc_data};
    assign w_sum       = w_acc_ext + w_bias_al;

    // Rescale, ReLU and saturate on the stage-1 sum.
    assign w_shift = r_s1_sum >>> FRAC;

    always_comb begin
        w_result = w_shift[15:0];
        if (w_shift[SUM_W-1]) begin
            w_result = 16'h0000;
        end else if (|w_shift[SUM_W-2:15]) begin
            w_result = 16'h7FFF;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_xfer && w_last_elem) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_final_hs && !r_s1_valid) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_ch_cnt   <= '0;
            r_pix_cnt  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_sum   <= '0;
            r_s1_ch    <= '0;
            r_s1_last  <= 1'b0;
            r_s2_valid <= 1'b0;
            r_out_data <= 16'h0000;
            r_out_ch   <= '0;
            r_out_last <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);

            if ((r_state == S_IDLE) && start) begin
                r_ch_cnt  <= '0;
                r_pix_cnt <= '0;
            end else if (w_xfer) begin
                if (r_ch_cnt == C_CH_MAX) begin
                    r_ch_cnt  <= '0;
                    r_pix_cnt <= (r_pix_cnt == C_PIX_MAX) ? '0 : r_pix_cnt + PIX_W'(1);
                end else begin
                    r_ch_cnt <= r_ch_cnt + CH_W'(1);
                end
            end

            if (w_advance) begin
                r_s1_valid <= w_xfer;
                if (w_xfer) begin
                    r_s1_sum  <= w_sum;
                    r_s1_ch   <= r_ch_cnt;
                    r_s1_last <= w_last_elem;
                end
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_out_data <= w_result;
                    r_out_ch   <= r_s1_ch;
                    r_out_last <= r_s1_last;
                end else begin
                    r_out_last <= 1'b0;
                end
            end
        end
    end

    assign acc_ready = w_acc_ready;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
    assign out_last  = r_out_last;
    assign out_valid = r_s2_valid;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule
`default_nettype wire
